// File: rtl/alu_acc_bank_if.sv
// Op/result bus for alu_acc_bank.
//   master: sequencer side (drives in_valid/op/sel/in_data, receives in_ready and results)
//   slave : the accumulator bank
//   in_valid/in_ready : op handshake, accept on both high at a rising edge
//   op/sel/in_data    : opcode, target accumulator, operand
//   out_valid         : one-cycle result strobe
//   out_sel/out_data/out_flags : accumulator index, value and {C,Z,N,V} after the op
interface alu_acc_bank_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               op;
  logic [$clog2(NREGS)-1:0] sel;
  logic [WIDTH-1:0]         in_data;
  logic                     out_valid;
  logic [$clog2(NREGS)-1:0] out_sel;
  logic [WIDTH-1:0]         out_data;
  logic [3:0]               out_flags;

  modport master (output in_valid, op, sel, in_data,
                  input  in_ready, out_valid, out_sel, out_data, out_flags);
  modport slave  (input  in_valid, op, sel, in_data,
                  output in_ready, out_valid, out_sel, out_data, out_flags);
endinterface

// File: rtl/alu_acc_bank.sv
// Bank of NREGS accumulators sharing one ALU. Single-cycle ops write at the
// accept edge and strobe the result the following cycle; MUL is a shift-add
// iteration taking WIDTH cycles with in_ready low while it runs.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_acc_bank_if slave (op handshake + result strobe)
module alu_acc_bank #(
  parameter int WIDTH    = 8,
  parameter int NREGS    = 4,
  parameter int SATURATE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_acc_bank_if.slave  bus
);
  localparam int SW = $clog2(NREGS);
  localparam int LW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_NEG = 4'd3, OP_CLR = 4'd4,
                         OP_NOT = 4'd5, OP_XOR = 4'd6, OP_AND = 4'd7, OP_OR  = 4'd8,
                         OP_SHL = 4'd9, OP_SAR = 4'd10, OP_MUL = 4'd11, OP_LD = 4'd12;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, nstate;

  logic [NREGS-1:0][WIDTH-1:0] acc;
  logic [3:0]                  flags;
  logic                        ov_q;
  logic [SW-1:0]               osel_q, msel, wr_sel;
  logic [WIDTH-1:0]            odata_q;
  logic [3:0]                  oflags_q;

  logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [LW-1:0]      cnt;

  logic               accept, mul_done, is_mul, hold, wr, wr_en, c, v;
  logic [WIDTH-1:0]   a, d, res, mres, wr_data;
  logic [WIDTH:0]     sum, shl_t;
  logic signed [WIDTH:0] sar_t;
  logic [LW-1:0]      sh;
  logic [3:0]         aflags, mflags;

  assign a      = acc[bus.sel];
  assign d      = bus.in_data;
  assign sh     = d[LW-1:0];
  assign accept = bus.in_valid & bus.in_ready;
  assign bus.in_ready = (state == IDLE);

  // Extra bit above/below the operand catches the last bit shifted out;
  // for a zero shift it stays 0, which is the required carry.
  assign shl_t = {1'b0, a} << sh;
  assign sar_t = $signed({a, 1'b0}) >>> sh;

  always_comb begin
    res = a; c = 1'b0; v = 1'b0; wr = 1'b1; hold = 1'b0; is_mul = 1'b0; sum = '0;
    case (bus.op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, d};
        res = sum[WIDTH-1:0]; c = sum[WIDTH];
        v   = (a[WIDTH-1] == d[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a} - {1'b0, d};           // top bit set exactly when a < d
        res = sum[WIDTH-1:0]; c = sum[WIDTH];
        v   = (a[WIDTH-1] != d[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NEG: begin res = -a; c = |a; v = (a == SMIN); end
      OP_CLR: res = '0;
      OP_NOT: res = ~a;
      OP_XOR: res = a ^ d;
      OP_AND: res = a & d;
      OP_OR:  res = a | d;
      OP_SHL: begin res = shl_t[WIDTH-1:0]; c = shl_t[WIDTH]; end
      OP_SAR: begin res = sar_t[WIDTH:1];   c = sar_t[0];     end
      OP_MUL: begin wr = 1'b0; is_mul = 1'b1; end
      OP_LD:  res = d;
      default: begin wr = 1'b0; hold = 1'b1; end
    endcase
    // v is only ever set by ADD/SUB/NEG. NEG overflows only from SMIN, which
    // must clamp positive even though a is negative.
    if (SATURATE != 0 && v)
      res = (bus.op == OP_NEG || !a[WIDTH-1]) ? SMAX : SMIN;
    aflags = {c, res == '0, res[WIDTH-1], v};
  end

  // Shift-add: the final partial product is folded in combinationally so the
  // result lands on the WIDTH-th edge after accept.
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign mres     = prod_nxt[WIDTH-1:0];
  assign mflags   = {1'b0, mres == '0, mres[WIDTH-1], |prod_nxt[2*WIDTH-1:WIDTH]};
  assign mul_done = (state == BUSY) && (cnt == LW'(WIDTH-1));

  assign wr_en   = (accept && wr) || mul_done;
  assign wr_sel  = mul_done ? msel : bus.sel;
  assign wr_data = mul_done ? mres : res;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept && is_mul) nstate = BUSY;
      BUSY:    if (mul_done)         nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0; flags <= '0;
      ov_q <= 1'b0; osel_q <= '0; odata_q <= '0; oflags_q <= '0;
      mcand <= '0; prod <= '0; mplier <= '0; cnt <= '0; msel <= '0;
    end else begin
      ov_q <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        if (wr_en && wr_sel == SW'(i)) acc[i] <= wr_data;

      if (accept && is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= d;
        prod   <= '0;
        cnt    <= '0;
        msel   <= bus.sel;
      end else if (accept) begin
        flags    <= hold ? flags : aflags;
        ov_q     <= 1'b1;
        osel_q   <= bus.sel;
        odata_q  <= res;
        oflags_q <= hold ? flags : aflags;
      end

      if (state == BUSY) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        prod   <= prod_nxt;
        cnt    <= cnt + LW'(1);
        if (mul_done) begin
          flags    <= mflags;
          ov_q     <= 1'b1;
          osel_q   <= msel;
          odata_q  <= mres;
          oflags_q <= mflags;
        end
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_sel   = osel_q;
  assign bus.out_data  = odata_q;
  assign bus.out_flags = oflags_q;
endmodule

// File: tb/tb_alu_acc_bank.sv
// Bench for alu_acc_bank: one plain and one saturating instance driven with
// identical ops. Expected results are queued when an op is driven and checked
// when the result strobe appears. Flags are {C,Z,N,V}.
module tb_alu_acc_bank;
  localparam logic [3:0] OP_HOLD = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_NEG = 4'd3,
                         OP_CLR = 4'd4, OP_NOT = 4'd5, OP_XOR = 4'd6, OP_AND = 4'd7,
                         OP_OR = 4'd8, OP_SHL = 4'd9, OP_SAR = 4'd10, OP_MUL = 4'd11,
                         OP_LD = 4'd12, OP_H14 = 4'd14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_acc_bank_if #(.WIDTH(8), .NREGS(4)) b0 ();
  alu_acc_bank_if #(.WIDTH(8), .NREGS(4)) b1 ();

  alu_acc_bank #(.WIDTH(8), .NREGS(4), .SATURATE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  alu_acc_bank #(.WIDTH(8), .NREGS(4), .SATURATE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  typedef struct {
    logic [1:0] sel; logic [7:0] d; logic [3:0] f; logic [3:0] m;
  } exp_t;

  typedef struct {
    logic [3:0] op; logic [1:0] sel; logic [7:0] d;
    logic [7:0] e0; logic [3:0] f0; logic [7:0] e1; logic [3:0] f1; logic [3:0] m1;
  } vec_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  vec_t tbl[$];
  int total = 0, bad = 0, strobes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic stray(input string name);
    total++; bad++;
    $display("FAIL %s: strobe with no pending result", name);
  endtask

  // Result monitor / scoreboard
  always @(negedge clk) begin
    if (b0.out_valid === 1'b1) begin
      strobes++;
      if (q0.size() == 0) stray("dut0");
      else begin
        e0 = q0.pop_front();
        chk("result dut0 {sel,data,flags}", {b0.out_sel, b0.out_data, b0.out_flags & e0.m},
            {e0.sel, e0.d, e0.f & e0.m});
      end
    end
    if (b1.out_valid === 1'b1) begin
      if (q1.size() == 0) stray("dut1");
      else begin
        e1 = q1.pop_front();
        chk("result dut1 {sel,data,flags}", {b1.out_sel, b1.out_data, b1.out_flags & e1.m},
            {e1.sel, e1.d, e1.f & e1.m});
      end
    end
  end

  task automatic drv(input logic vld, input logic [3:0] op, input logic [1:0] sel, input logic [7:0] d);
    b0.in_valid = vld; b0.op = op; b0.sel = sel; b0.in_data = d;
    b1.in_valid = vld; b1.op = op; b1.sel = sel; b1.in_data = d;
  endtask

  // Called at a falling edge; returns at the next falling edge (one accept).
  task automatic send(input logic [3:0] op, input logic [1:0] sel, input logic [7:0] d,
                      input logic [7:0] x0, input logic [3:0] f0, input logic [3:0] m0,
                      input logic [7:0] x1, input logic [3:0] f1, input logic [3:0] m1);
    drv(1'b1, op, sel, d);
    q0.push_back('{sel, x0, f0, m0});
    q1.push_back('{sel, x1, f1, m1});
    @(negedge clk);
  endtask

  task automatic add(input logic [3:0] op, input logic [1:0] sel, input logic [7:0] d,
                     input logic [7:0] x0, input logic [3:0] f0,
                     input logic [7:0] x1, input logic [3:0] f1, input logic [3:0] m1);
    tbl.push_back('{op, sel, d, x0, f0, x1, f1, m1});
  endtask

  // MUL with latency and ignored-while-busy checks; junk LOAD held valid during BUSY.
  task automatic mul_chk(input logic [1:0] sel, input logic [7:0] d,
                         input logic [7:0] x, input logic [3:0] f);
    send(OP_MUL, sel, d, x, f, 4'b0111, x, f, 4'b0111);
    drv(1'b1, OP_LD, sel, 8'hEE);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("busy cycle %0d {rdy0,rdy1,ov0,ov1}", k),
          {b0.in_ready, b1.in_ready, b0.out_valid, b1.out_valid}, 4'b0000);
      @(negedge clk);
    end
    chk("mul done {rdy0,rdy1,ov0,ov1}", {b0.in_ready, b1.in_ready, b0.out_valid, b1.out_valid}, 4'b1111);
    drv(1'b0, OP_HOLD, 2'd0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int guard;
    // op   sel  d      plain: data  flags   sat: data  flags   sat mask
    add(OP_ADD, 2'd0, 8'h05, 8'h05, 4'b0000, 8'h05, 4'b0000, 4'hF);
    add(OP_SUB, 2'd0, 8'h03, 8'h02, 4'b0000, 8'h02, 4'b0000, 4'hF);
    add(OP_SUB, 2'd0, 8'h03, 8'hFF, 4'b1010, 8'hFF, 4'b1010, 4'hF);
    add(OP_CLR, 2'd0, 8'h00, 8'h00, 4'b0100, 8'h00, 4'b0100, 4'hF);
    add(OP_ADD, 2'd0, 8'd120, 8'h78, 4'b0000, 8'h78, 4'b0000, 4'hF);
    add(OP_ADD, 2'd0, 8'd57, 8'hB1, 4'b0011, 8'h7F, 4'b0001, 4'hF);
    add(OP_CLR, 2'd0, 8'h00, 8'h00, 4'b0100, 8'h00, 4'b0100, 4'hF);
    add(OP_ADD, 2'd0, 8'h88, 8'h88, 4'b0010, 8'h88, 4'b0010, 4'hF);
    add(OP_ADD, 2'd0, 8'hC7, 8'h4F, 4'b1001, 8'h80, 4'b0011, 4'b0111);
    add(OP_LD,  2'd2, 8'h80, 8'h80, 4'b0010, 8'h80, 4'b0010, 4'hF);
    add(OP_NEG, 2'd2, 8'h00, 8'h80, 4'b1011, 8'h7F, 4'b0001, 4'b0111);
    add(OP_LD,  2'd2, 8'h96, 8'h96, 4'b0010, 8'h96, 4'b0010, 4'hF);
    add(OP_SHL, 2'd2, 8'hF4, 8'h60, 4'b1000, 8'h60, 4'b1000, 4'hF);
    add(OP_LD,  2'd2, 8'h96, 8'h96, 4'b0010, 8'h96, 4'b0010, 4'hF);
    add(OP_SAR, 2'd2, 8'h02, 8'hE5, 4'b1010, 8'hE5, 4'b1010, 4'hF);
    add(OP_SAR, 2'd2, 8'h08, 8'hE5, 4'b0010, 8'hE5, 4'b0010, 4'hF);
    add(OP_NOT, 2'd2, 8'h00, 8'h1A, 4'b0000, 8'h1A, 4'b0000, 4'hF);
    add(OP_XOR, 2'd2, 8'hFF, 8'hE5, 4'b0010, 8'hE5, 4'b0010, 4'hF);
    add(OP_AND, 2'd2, 8'h0F, 8'h05, 4'b0000, 8'h05, 4'b0000, 4'hF);
    add(OP_OR,  2'd2, 8'hF0, 8'hF5, 4'b0010, 8'hF5, 4'b0010, 4'hF);
    add(OP_LD,  2'd2, 8'h80, 8'h80, 4'b0010, 8'h80, 4'b0010, 4'hF);
    add(OP_SUB, 2'd2, 8'h01, 8'h7F, 4'b0001, 8'h80, 4'b0011, 4'hF);
    add(OP_AND, 2'd2, 8'h00, 8'h00, 4'b0100, 8'h00, 4'b0100, 4'hF);
    add(OP_H14, 2'd2, 8'h55, 8'h00, 4'b0100, 8'h00, 4'b0100, 4'hF);
    add(OP_LD,  2'd0, 8'hAA, 8'hAA, 4'b0010, 8'hAA, 4'b0010, 4'hF);
    add(OP_LD,  2'd3, 8'h55, 8'h55, 4'b0000, 8'h55, 4'b0000, 4'hF);
    add(OP_HOLD,2'd0, 8'h00, 8'hAA, 4'b0000, 8'hAA, 4'b0000, 4'hF);
    add(OP_HOLD,2'd3, 8'h00, 8'h55, 4'b0000, 8'h55, 4'b0000, 4'hF);
    add(OP_LD,  2'd1, 8'h0D, 8'h0D, 4'b0000, 8'h0D, 4'b0000, 4'hF);

    // Reset state
    drv(1'b0, OP_HOLD, 2'd0, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset {rdy0,rdy1,ov0,ov1}", {b0.in_ready, b1.in_ready, b0.out_valid, b1.out_valid}, 4'b1100);
    chk("reset outputs dut0", {b0.out_sel, b0.out_data, b0.out_flags}, 0);
    chk("reset outputs dut1", {b1.out_sel, b1.out_data, b1.out_flags}, 0);

    // Table, applied back-to-back
    foreach (tbl[i])
      send(tbl[i].op, tbl[i].sel, tbl[i].d, tbl[i].e0, tbl[i].f0, 4'hF,
           tbl[i].e1, tbl[i].f1, tbl[i].m1);

    // Multi-cycle MUL (carry not defined for MUL, masked)
    mul_chk(2'd1, 8'd11, 8'h8F, 4'b0010);
    send(OP_HOLD, 2'd1, 8'h00, 8'h8F, 4'b0010, 4'b0111, 8'h8F, 4'b0010, 4'b0111);
    send(OP_LD,   2'd1, 8'h20, 8'h20, 4'b0000, 4'hF, 8'h20, 4'b0000, 4'hF);
    mul_chk(2'd1, 8'h10, 8'h00, 4'b0101);
    send(OP_HOLD, 2'd1, 8'h00, 8'h00, 4'b0101, 4'b0111, 8'h00, 4'b0101, 4'b0111);

    // Reset in the middle of a MUL
    for (int r = 0; r < 4; r++)
      send(OP_LD, 2'(r), 8'h33, 8'h33, 4'b0000, 4'hF, 8'h33, 4'b0000, 4'hF);
    send(OP_MUL, 2'd2, 8'h02, 8'h66, 4'b0000, 4'b0111, 8'h66, 4'b0000, 4'b0111);
    drv(1'b0, OP_HOLD, 2'd0, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete(); q1.delete();
    s = strobes;
    chk("after mid-MUL reset {rdy0,rdy1,ov0,ov1}",
        {b0.in_ready, b1.in_ready, b0.out_valid, b1.out_valid}, 4'b1100);
    repeat (12) @(negedge clk);
    chk("strobes after aborted MUL", strobes - s, 0);
    chk("outputs after reset dut0", {b0.out_sel, b0.out_data, b0.out_flags}, 0);
    chk("outputs after reset dut1", {b1.out_sel, b1.out_data, b1.out_flags}, 0);
    for (int r = 0; r < 4; r++)
      send(OP_HOLD, 2'(r), 8'h00, 8'h00, 4'b0000, 4'hF, 8'h00, 4'b0000, 4'hF);
    drv(1'b0, OP_HOLD, 2'd0, 8'h00);

    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("pending results at end", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
